// File: rtl/pix_pkg.sv
// Shared pixel-path definitions: data widths and the per-pixel qualifier bundle.
package pix_pkg;

    localparam int unsigned PIX_W = 8;   // one colour channel / luminance sample
    localparam int unsigned SUM_W = 10;  // weighted 1-2-1 column/row sum
    localparam int unsigned MAG_W = 11;  // signed gradient and |Gx|+|Gy|

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
    } qual_t;

endpackage

// File: rtl/line_buffer.sv
// One video line of luminance storage.
// Single-port RAM, combinational read-before-write at the same address.
// Ports: clk; i_we write enable; i_addr column; i_wdata sample to store;
//        o_rdata_c sample stored at i_addr before this cycle's write.
module line_buffer
    import pix_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata_c
);

    // Contents are never reset; border masking hides stale data.
    logic [PIX_W-1:0] r_mem [DEPTH];

    assign o_rdata_c = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector with RGB passthrough, fixed 2-cycle latency.
// Ports: clk; rst (sync, active-low); enable (edge mode, latched at accepted sof);
//        thresh (0 = magnitude output, else binarise); in_valid/in_sof/in_eol and
//        in_R/G/B (in_G is luminance); out_R/G/B result; out_valid/out_sof/out_eol
//        are the input qualifiers delayed 2 cycles.
module sobel_edge
    import pix_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned CW       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PIX_W-1:0] thresh,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [PIX_W-1:0] in_R,
    input  logic [PIX_W-1:0] in_G,
    input  logic [PIX_W-1:0] in_B,
    output logic [PIX_W-1:0] out_R,
    output logic [PIX_W-1:0] out_G,
    output logic [PIX_W-1:0] out_B,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol
);

    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);

    // Position/mode state; r_col is the column the next pixel will occupy.
    logic [CW-1:0]    r_col;
    logic             r_past;
    logic [1:0]       r_row;
    logic             r_mode;

    logic [CW-1:0]    w_col;
    logic [1:0]       w_row;
    logic             w_past;
    logic             w_mode;
    logic             w_border;
    logic             w_we;
    logic [PIX_W-1:0] w_lb0;
    logic [PIX_W-1:0] w_lb1;

    // Stage 1
    logic [PIX_W-1:0] r_win [3][3];
    qual_t            r_s1_q;
    logic             r_s1_border;
    logic             r_s1_mode;
    logic [PIX_W-1:0] r_s1_r;
    logic [PIX_W-1:0] r_s1_g;
    logic [PIX_W-1:0] r_s1_b;

    // Stage 2 combinational datapath
    logic [SUM_W-1:0]        w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [MAG_W-1:0] w_gx, w_gy;
    logic [MAG_W-1:0]        w_abs_x, w_abs_y, w_mag;
    logic [PIX_W-1:0]        w_sat, w_bin, w_res;

    // Position of the pixel currently presented; sof restarts the frame in place.
    always_comb begin
        w_col    = in_sof ? '0 : r_col;
        w_row    = in_sof ? 2'd0 : r_row;
        w_past   = !in_sof && r_past;
        w_mode   = in_sof ? enable : r_mode;
        w_border = (w_row < 2'd2) || (w_col < CW'(2)) || w_past;
        w_we     = in_valid && !w_past;
    end

    // Column/row counters and frame-latched mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col  <= '0;
            r_past <= 1'b0;
            r_row  <= 2'd0;
            r_mode <= 1'b0;
        end else if (in_valid) begin
            r_mode <= w_mode;
            if (in_eol) begin
                r_col  <= '0;
                r_past <= 1'b0;
                r_row  <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
            end else begin
                r_row <= w_row;
                if (w_col == COL_LAST) begin
                    // Saturate; later pixels of this line are ignored.
                    r_col  <= w_col;
                    r_past <= 1'b1;
                end else begin
                    r_col  <= w_col + CW'(1);
                    r_past <= 1'b0;
                end
            end
        end
    end

    // lb0 holds the previous line, lb1 the line before that.
    line_buffer #(.DEPTH(H_ACTIVE), .AW(CW)) u_lb0 (
        .clk       (clk),
        .i_we      (w_we),
        .i_addr    (w_col),
        .i_wdata   (in_G),
        .o_rdata_c (w_lb0)
    );

    line_buffer #(.DEPTH(H_ACTIVE), .AW(CW)) u_lb1 (
        .clk       (clk),
        .i_we      (w_we),
        .i_addr    (w_col),
        .i_wdata   (w_lb0),
        .o_rdata_c (w_lb1)
    );

    // Stage 1: window shift plus side-band registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_s1_q      <= '0;
            r_s1_border <= 1'b1;
            r_s1_mode   <= 1'b0;
            r_s1_r      <= '0;
            r_s1_g      <= '0;
            r_s1_b      <= '0;
        end else begin
            r_s1_q.valid <= in_valid;
            r_s1_q.sof   <= in_valid && in_sof;
            r_s1_q.eol   <= in_valid && in_eol;
            r_s1_border  <= w_border;
            r_s1_mode    <= w_mode;
            r_s1_r       <= in_R;
            r_s1_g       <= in_G;
            r_s1_b       <= in_B;
            if (w_we) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb1;
                r_win[1][2] <= w_lb0;
                r_win[2][2] <= in_G;
            end
        end
    end

    // Gradients, magnitude, saturation and threshold.
    always_comb begin
        w_gx_pos = SUM_W'(r_win[0][2]) + SUM_W'({r_win[1][2], 1'b0}) + SUM_W'(r_win[2][2]);
        w_gx_neg = SUM_W'(r_win[0][0]) + SUM_W'({r_win[1][0], 1'b0}) + SUM_W'(r_win[2][0]);
        w_gy_pos = SUM_W'(r_win[2][0]) + SUM_W'({r_win[2][1], 1'b0}) + SUM_W'(r_win[2][2]);
        w_gy_neg = SUM_W'(r_win[0][0]) + SUM_W'({r_win[0][1], 1'b0}) + SUM_W'(r_win[0][2]);
        w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
        w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
        w_abs_x  = w_gx[MAG_W-1] ? MAG_W'(-w_gx) : MAG_W'(w_gx);
        w_abs_y  = w_gy[MAG_W-1] ? MAG_W'(-w_gy) : MAG_W'(w_gy);
        w_mag    = w_abs_x + w_abs_y;
        w_sat    = (w_mag > MAG_W'(255)) ? '1 : w_mag[PIX_W-1:0];
        w_bin    = (w_mag >= MAG_W'(thresh)) ? '1 : '0;
        w_res    = '0;
        if (!r_s1_border) begin
            w_res = (thresh == '0) ? w_sat : w_bin;
        end
    end

    // Stage 2: output mux and qualifiers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_R     <= '0;
            out_G     <= '0;
            out_B     <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= r_s1_q.valid;
            out_sof   <= r_s1_q.sof;
            out_eol   <= r_s1_q.eol;
            if (r_s1_mode) begin
                out_R <= w_res;
                out_G <= w_res;
                out_B <= w_res;
            end else begin
                out_R <= r_s1_r;
                out_G <= r_s1_g;
                out_B <= r_s1_b;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: driver pushes expected pixels, monitor pops and compares.
module tb_sobel_edge;

    localparam int unsigned H  = 8;
    localparam int unsigned CW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] thresh;
    logic       in_valid, in_sof, in_eol;
    logic [7:0] in_R, in_G, in_B;
    logic [7:0] out_R, out_G, out_B;
    logic       out_valid, out_sof, out_eol;

    sobel_edge #(.H_ACTIVE(H), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .in_R      (in_R),
        .in_G      (in_G),
        .in_B      (in_B),
        .out_R     (out_R),
        .out_G     (out_G),
        .out_B     (out_B),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         cyc;
        int         tid;
        logic       sof;
        logic       eol;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tid   = 0;
    bit   gaps_on = 0;

    // Test images: 0 flat, 1 vertical step at col 4, 2 ramp 10*col, 3 horizontal step at row 2.
    function automatic logic [7:0] img(input int pat, input int l, input int c);
        case (pat)
            0:       return 8'h80;
            1:       return (c >= 4) ? 8'hFF : 8'h00;
            2:       return 8'(10 * c);
            default: return (l >= 2) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // Hand-derived expected edge output for each image.
    function automatic logic [7:0] exp_px(input int pat, input int l, input int c, input logic [7:0] thr);
        if (l < 2 || c < 2) return 8'h00;
        case (pat)
            0:       return 8'h00;
            1:       return (c == 4 || c == 5) ? 8'hFF : 8'h00;            // |Gx| = 1020
            2:       return (thr == 8'd0) ? 8'd80 :
                            ((8'd80 >= thr) ? 8'hFF : 8'h00);             // |Gx| = 80
            default: return (l == 2 || l == 3) ? 8'hFF : 8'h00;            // |Gy| = 1020
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'($urandom_range(0, 1));
            in_eol   = 1'($urandom_range(0, 1));
            in_R     = 8'($urandom);
            in_G     = 8'($urandom);
            in_B     = 8'($urandom);
        end
    endtask

    task automatic send(input logic sof, input logic eol, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic edge_exp, input logic [7:0] e);
        exp_t x;
        if (gaps_on && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_eol   = eol;
        in_R     = r;
        in_G     = g;
        in_B     = b;
        x.cyc = cyc + 2;
        x.tid = tid;
        x.sof = sof;
        x.eol = eol;
        x.r   = edge_exp ? e : r;
        x.g   = edge_exp ? e : g;
        x.b   = edge_exp ? e : b;
        sbq.push_back(x);
    endtask

    task automatic send_img(input int pat, input int l, input int c, input logic edge_exp,
                            input logic [7:0] thr);
        logic [7:0] y;
        y = img(pat, l, c);
        send(l == 0 && c == 0, c == int'(H) - 1, ~y, y, y ^ 8'h0F, edge_exp, exp_px(pat, l, c, thr));
    endtask

    task automatic frame(input int pat, input int nlines, input logic en, input logic edge_exp,
                         input int toggle_at, input logic [7:0] thr);
        thresh = thr;
        enable = en;
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < int'(H); c++) begin
                if (l * int'(H) + c == toggle_at) enable = !en;
                send_img(pat, l, c, edge_exp, thr);
            end
        end
        idle(4);
    endtask

    // Monitor: every presented output is checked against the queue head, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out cyc=%0d got valid with rgb=%h_%h_%h want no output",
                             cyc, out_R, out_G, out_B);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || out_sof !== e.sof || out_eol !== e.eol ||
                        out_R !== e.r || out_G !== e.g || out_B !== e.b) begin
                        n_err++;
                        $display("FAIL out_px tid=%0d cyc got=%0d want=%0d sof/eol got=%b%b want=%b%b rgb got=%h_%h_%h want=%h_%h_%h",
                                 e.tid, cyc, e.cyc, out_sof, out_eol, e.sof, e.eol,
                                 out_R, out_G, out_B, e.r, e.g, e.b);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_out tid=%0d cyc=%0d got valid=%b want valid=1", e.tid, cyc, out_valid);
            end
        end
    end

    initial begin
        rst      = 1'b0;
        enable   = 1'b0;
        thresh   = 8'd0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_eol   = 1'b0;
        in_R     = 8'hAA;
        in_G     = 8'hBB;
        in_B     = 8'hCC;

        // Reset held with traffic: every output must be zero.
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({out_R, out_G, out_B, out_valid, out_sof, out_eol} !== 27'd0) begin
                n_err++;
                $display("FAIL reset_outputs got=%h_%h_%h v%b s%b e%b want all 0",
                         out_R, out_G, out_B, out_valid, out_sof, out_eol);
            end
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;

        // Passthrough
        tid = 1;
        send(1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 8'h00);
        send(1'b0, 1'b0, 8'hAB, 8'hCD, 8'hEF, 1'b0, 8'h00);
        send(1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 1'b0, 8'h00);
        send(1'b1, 1'b1, 8'h77, 8'h88, 8'h99, 1'b0, 8'h00);
        idle(4);

        tid = 2;  frame(0, 4, 1'b1, 1'b1, -1, 8'd0);     // flat
        tid = 3;  frame(1, 4, 1'b1, 1'b1, -1, 8'd0);     // vertical step
        tid = 4;  frame(1, 4, 1'b1, 1'b1, -1, 8'd200);
        tid = 5;  frame(2, 4, 1'b1, 1'b1, -1, 8'd0);     // ramp, unsaturated 80
        tid = 6;  frame(2, 4, 1'b1, 1'b1, -1, 8'd80);    // threshold equal -> 255
        tid = 7;  frame(2, 4, 1'b1, 1'b1, -1, 8'd81);    // threshold above -> 0
        tid = 8;  frame(3, 5, 1'b1, 1'b1, -1, 8'd0);     // horizontal step

        gaps_on = 1;
        tid = 9;  frame(1, 4, 1'b1, 1'b1, -1, 8'd0);
        tid = 10; frame(3, 5, 1'b1, 1'b1, -1, 8'd200);
        tid = 11; frame(1, 4, 1'b1, 1'b1, 10, 8'd0);     // enable drops mid-frame
        tid = 12; frame(1, 4, 1'b0, 1'b0, 10, 8'd0);     // enable rises mid-frame
        gaps_on = 0;

        // Mid-frame reset in row 2 with one pixel still in flight.
        tid = 13;
        enable = 1'b1;
        thresh = 8'd0;
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < int'(H); c++) begin
                if (l < 2 || c < 3) send_img(1, l, c, 1'b1, 8'd0);
            end
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        void'(sbq.pop_back());
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            n_err++;
            $display("FAIL midreset_quals got=v%b s%b e%b want 000", out_valid, out_sof, out_eol);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int l = 2; l < 4; l++) begin
            for (int c = 0; c < int'(H); c++) begin
                if (l == 3 || c >= 3) begin
                    logic [7:0] y;
                    y = img(1, l, c);
                    send(1'b0, c == int'(H) - 1, ~y, y, y ^ 8'h0F, 1'b0, 8'h00);
                end
            end
        end
        idle(4);
        tid = 14; frame(1, 4, 1'b1, 1'b1, -1, 8'd0);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending got=%0d want=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3×3 Sobel edge detector that sits directly downstream of the `grayscale` stage in the D8M camera loopback pixel path. It takes the 8-bit luminance channel, keeps two line buffers and a 3×3 window, and outputs gradient magnitude on all three colour channels. When disabled, it forwards RGB unchanged with the same fixed latency. Mode changes take effect only at frame start, so a frame is never split between modes.

## Interface
- `H_ACTIVE`, 640: active pixels per line; sets the line-buffer depth.
- `CW`, 10: column counter width; must satisfy 2^CW ≥ H_ACTIVE.
- `clk` in 1: pixel clock; the single clock domain.
- `rst` in 1: reset; synchronous, active-low.
- `enable` in 1: edge mode request; sampled only on an accepted start-of-frame.
- `thresh` in 8: binarise level; 0 means greyscale magnitude output.
- `in_valid` in 1: input pixel qualifier.
- `in_sof` in 1: first pixel of a frame; meaningful only when `in_valid` is high.
- `in_eol` in 1: last pixel of a line; meaningful only when `in_valid` is high.
- `in_R`, `in_G`, `in_B` in 8 each: pixel from `grayscale`; `in_G` carries luminance.
- `out_R`, `out_G`, `out_B` out 8 each: result pixel.
- `out_valid`, `out_sof`, `out_eol` out 1 each: input qualifiers delayed by 2 cycles.

## Operation
- **Accepted pixel:** a cycle with `in_valid` = 1. The window, line buffers and counters advance only on accepted pixels.
- **Mode register `mode`:** loads `enable` on an accepted `in_sof`. It holds for the rest of the frame.
- **Column counter `col`:**
  - Cleared to 0 on an accepted pixel with `in_sof` or `in_eol`; increments on other accepted pixels.
  - Saturates at H_ACTIVE−1. Pixels past that point are neither written to the line buffers nor used, and their output is 0 in edge mode.
- **Row counter `row`:** cleared on an accepted `in_sof`. Increments on an accepted `in_eol` and saturates at 2, since it is only needed for border detection.
- **Line buffers `lb0`/`lb1`:**
  - Read at `col` with read-before-write.
  - `lb0` receives the current Y; `lb1` receives the old `lb0` value.
  - The window columns are therefore {`lb1` out, `lb0` out, Y}.
- **Window and gradients:**
  - The window shifts left on every accepted pixel. p[r][c] is the pixel at row r, column c, with r,c = 0 as the oldest.
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - Each sum is 10-bit unsigned. Each difference is 11-bit signed, range ±1020.
  - mag = |Gx| + |Gy|, 11-bit unsigned, maximum 2040. It saturates to 255.
- **Output convention:** the window ends at the current pixel, so the edge image is offset by one pixel down and right. This is accepted.
- **Border:** if `row` < 2 or `col` < 2 at the time the pixel is accepted, the result is forced to 0.
- **Output value:**
  - If `thresh` = 0, the result is the saturated mag.
  - Otherwise the result is 255 when mag ≥ `thresh`, else 0.
  - In edge mode, `out_R` = `out_G` = `out_B` = result.
- **Passthrough:** with `mode` = 0, `out_R/G/B` equal `in_R/G/B` delayed 2 cycles. The line buffers keep updating so that enabling mid-stream is clean at the next frame.
- **Reset:**
  - All outputs are 0; `out_valid`/`out_sof`/`out_eol` are 0.
  - `mode` = 0, `col` = 0, `row` = 0, window = 0.
  - Line-buffer contents are not cleared; the border masking hides them.

## Timing
- Fixed latency of 2 cycles from input to output in both modes, independent of `in_valid` gaps.
- Stage 1 registers:
  - the window after the shift;
  - a border flag and the input RGB;
  - the qualifiers;
  - the mode in effect, which is the new `enable` value when this pixel is an accepted `in_sof`.
- Stage 2 registers:
  - abs / sum / saturate / threshold;
  - the output mux.
- Idle cycles (`in_valid` = 0): the qualifiers propagate as 0. Output data then holds don't-care values, but must not alter state.
- `in_sof` and `in_eol` together on one pixel (one-pixel lines): `col` clears, `row` increments after the sof clear, and that pixel's output is border 0.
- Reset asserted mid-frame:
  - Output qualifiers are 0 on the next cycle.
  - Passthrough resumes immediately.
  - Edge mode resumes only after the next accepted `in_sof` with `enable` = 1.
- `thresh` is sampled in stage 2 without registering; a change applies within 1 cycle.

## Structure
- Shared package `pix_pkg`:
  - the pixel width constant (8);
  - the magnitude width (11);
  - the qualifier struct type {valid, sof, eol}.
- Sub-module `line_buffer`:
  - H_ACTIVE × 8 single-port RAM;
  - read-before-write, one write enable, address `col`;
  - instantiated twice.
- The counters, window, gradients and output pipeline live in `sobel_edge`.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with `in_valid` = 1. Require all outputs = 0. On release, require `out_valid` to follow `in_valid` 2 cycles later.
- **Passthrough:** `enable` = 0 and pixel RGB = (0x12, 0x34, 0x56). Require out = (0x12, 0x34, 0x56) exactly 2 cycles later, with `out_sof`/`out_eol` aligned.
- **Flat image:** `enable` = 1, H_ACTIVE = 8 in the bench, every Y = 0x80 for 4 lines. Require all outputs = 0, including borders.
- **Vertical step edge:** columns 0–3 Y = 0, columns 4–7 Y = 255. Require row ≥ 2 outputs at col 4 and col 5 = 255 (mag 1020 saturated) and the rest 0. With `thresh` = 200, require the same pixels to be 255.
- **Gaps and mode latch:** insert random `in_valid` = 0 gaps. Require results identical to the gap-free run. Toggle `enable` mid-frame and require no mode change until the next `in_sof`.
- **Mid-frame reset:** assert `rst` during row 2 of a frame. Require passthrough until the next `in_sof`, then correct edges.
